// File: rtl/pixel_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_scan_gen
//  Purpose  : Raster coordinate generator. Sweeps (x, y) over a programmable
//             active area and presents each coordinate as a valid/ready beat
//             with start-of-frame and end-of-line markers. Supports
//             single-shot and continuous modes, graceful stop and a wrapping
//             frame counter.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             start, continuous  - launch control (sampled in IDLE)
//             stop               - finish current frame then go idle
//             h_active, v_active - area size, latched at each frame start
//             x, y, valid, ready - coordinate stream handshake
//             sof, eol           - frame-start / line-end markers
//             busy               - scanning in progress
//             frame_done         - one-cycle pulse after last beat of a frame
//             frame_count        - frames completed since reset (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module pixel_scan_gen #(
   parameter int X_W     = 10,
   parameter int Y_W     = 10,
   parameter int FRAME_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               continuous,
   input  logic               stop,
   input  logic [X_W-1:0]     h_active,
   input  logic [Y_W-1:0]     v_active,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic               valid,
   input  logic               ready,
   output logic               sof,
   output logic               eol,
   output logic               busy,
   output logic               frame_done,
   output logic [FRAME_W-1:0] frame_count
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [X_W-1:0]       x_q, x_d;
   logic [Y_W-1:0]       y_q, y_d;
   logic [X_W-1:0]       h_q, h_d;
   logic [Y_W-1:0]       v_q, v_d;
   logic                 cont_q, cont_d;
   logic                 stop_pend_q, stop_pend_d;
   logic                 frame_done_q, frame_done_d;
   logic [FRAME_W-1:0]   frame_count_q, frame_count_d;

   // A zero dimension would make the frame never terminate; treat it as 1.
   logic [X_W-1:0]       w_h_lat;
   logic [Y_W-1:0]       w_v_lat;
   logic                 w_last_x;
   logic                 w_last_y;

   assign w_h_lat  = (h_active == '0) ? X_W'(1) : h_active;
   assign w_v_lat  = (v_active == '0) ? Y_W'(1) : v_active;
   assign w_last_x = (x_q == h_q - X_W'(1));
   assign w_last_y = (y_q == v_q - Y_W'(1));

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      h_d           = h_q;
      v_d           = v_q;
      cont_d        = cont_q;
      stop_pend_d   = stop_pend_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;

      case (state_q)
         ST_IDLE: begin
            // start has priority; a coincident stop is simply not looked at
            if (start) begin
               state_d     = ST_RUN;
               x_d         = '0;
               y_d         = '0;
               h_d         = w_h_lat;
               v_d         = w_v_lat;
               cont_d      = continuous;
               stop_pend_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            if (ready) begin
               if (!w_last_x) begin
                  x_d = x_q + X_W'(1);
               end else begin
                  x_d = '0;
                  if (!w_last_y) begin
                     y_d = y_q + Y_W'(1);
                  end else begin
                     // last beat of the frame accepted
                     y_d           = '0;
                     frame_count_d = frame_count_q + FRAME_W'(1);
                     frame_done_d  = 1'b1;
                     // a stop arriving together with the last beat still counts
                     if (cont_q && !stop_pend_q && !stop) begin
                        h_d    = w_h_lat;
                        v_d    = w_v_lat;
                        cont_d = continuous;
                     end else begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                     end
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         x_q           <= '0;
         y_q           <= '0;
         h_q           <= X_W'(1);
         v_q           <= Y_W'(1);
         cont_q        <= 1'b0;
         stop_pend_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         h_q           <= h_d;
         v_q           <= v_d;
         cont_q        <= cont_d;
         stop_pend_q   <= stop_pend_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign valid       = (state_q == ST_RUN);
   assign busy        = (state_q == ST_RUN);
   assign x           = x_q;
   assign y           = y_q;
   assign sof         = valid && (x_q == '0) && (y_q == '0);
   assign eol         = valid && w_last_x;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;

endmodule
`default_nettype wire
